// File: rtl/mram_xfer_sched.sv
// rtl/mram_xfer_sched.sv - MRAM transfer scheduler: single/burst word issue to the serializer with abort.
module mram_xfer_sched #(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_mode,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              abort,
   output logic              ser_valid,
   output logic [ADDR_W-1:0] ser_addr,
   output logic              ser_last,
   input  logic              ser_ready,
   input  logic              ser_done,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  word_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  rem;
   logic              abort_pending;
   logic              last_q;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign ser_valid = (state == ISSUE);
   assign ser_addr  = cur_addr;
   assign ser_last  = last_q;
   assign done      = (state == DONE);
   assign aborted   = (state == DONE) && abort_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cur_addr      <= '0;
         rem           <= '0;
         abort_pending <= 1'b0;
         last_q        <= 1'b0;
         word_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cur_addr      <= req_addr;
                  word_cnt      <= '0;
                  abort_pending <= 1'b0;
                  // Singles ignore req_len; a zero-length burst still moves one word.
                  if (!req_mode || req_len == '0) begin
                     rem    <= LEN_W'(1);
                     last_q <= 1'b1;
                  end else begin
                     rem    <= req_len;
                     last_q <= (req_len == LEN_W'(1));
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (ser_ready) begin
                  if (abort) abort_pending <= 1'b1;
                  last_q <= 1'b0;
                  state  <= WAIT;
               end else if (abort) begin
                  abort_pending <= 1'b1;
                  last_q        <= 1'b0;
                  state         <= DONE;
               end
            end
            WAIT: begin
               if (abort) abort_pending <= 1'b1;
               if (ser_done) begin
                  word_cnt <= word_cnt + LEN_W'(1);
                  if (rem == LEN_W'(1) || abort_pending || abort) begin
                     state <= DONE;
                  end else begin
                     cur_addr <= cur_addr + ADDR_W'(1);
                     rem      <= rem - LEN_W'(1);
                     last_q   <= (rem == LEN_W'(2));
                     state    <= ISSUE;
                  end
               end
            end
            DONE: begin
               abort_pending <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
